boson_camera: RTL and testbench



---
 rtl/boson_camera.sv | 101 ++++++++++
 tb/tb_boson_camera.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/boson_camera.sv
// Behavioural model of a Boson thermal core's 16-bit parallel CMOS video port.
// Emits a continuous raster test pattern (pixel index + frame number) with line/frame sync.
module boson_camera #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 16,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 512,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        CMOS_CLK,
    output logic [15:0] CMOS_DQ,
    output logic        CMOS_VSYNC,
    output logic        CMOS_HSYNC,
    output logic        CMOS_VALID
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Every boundary is strictly below the total, so it fits the counter width.
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [15:0]   pix_q, pix_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   dq_q, dq_d;
    logic          valid_q, valid_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          h_wrap, v_wrap;

    always_comb begin
        h_wrap  = (h_q == H_LAST);
        v_wrap  = h_wrap && (v_q == V_LAST);

        valid_d = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d = (h_q >= H_SS) && (h_q < H_SE);
        vsync_d = (v_q >= V_SS) && (v_q < V_SE);
        dq_d    = valid_d ? (pix_q + frame_q) : 16'h0000;

        h_d     = h_wrap ? '0 : h_q + HW'(1);
        v_d     = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + VW'(1);
        end
        frame_d = v_wrap ? frame_q + 16'd1 : frame_q;

        // The wrap cycle is always in vertical blanking, so it never coincides with a valid pixel.
        pix_d   = pix_q;
        if (v_wrap) begin
            pix_d = 16'h0000;
        end else if (valid_d) begin
            pix_d = pix_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            pix_q   <= 16'h0000;
            frame_q <= 16'h0000;
            dq_q    <= 16'h0000;
            valid_q <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            pix_q   <= pix_d;
            frame_q <= frame_d;
            dq_q    <= dq_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // Data launches on clk rising so the receiver can sample on CMOS_CLK rising mid-eye.
    assign CMOS_CLK   = ~clk;
    assign CMOS_DQ    = dq_q;
    assign CMOS_VSYNC = vsync_q;
    assign CMOS_HSYNC = hsync_q;
    assign CMOS_VALID = valid_q;

endmodule

// File: tb/tb_boson_camera.sv
// Bench for boson_camera: a small-raster instance for directed checks and a
// default-parameter instance for line geometry, both scored from a queue of expectations.
module tb_boson_camera;

    typedef struct packed {
        logic [15:0] dq;
        logic        valid;
        logic        hsync;
        logic        vsync;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_d = 1'b1;

    logic        s_cclk, s_vsync, s_hsync, s_valid;
    logic [15:0] s_dq;
    logic        d_cclk, d_vsync, d_hsync, d_valid;
    logic [15:0] d_dq;

    exp_t        q[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;

    always #5 clk = ~clk;

    boson_camera #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .clk(clk), .reset(rst), .CMOS_CLK(s_cclk), .CMOS_DQ(s_dq),
        .CMOS_VSYNC(s_vsync), .CMOS_HSYNC(s_hsync), .CMOS_VALID(s_valid)
    );

    boson_camera u_dflt (
        .clk(clk), .reset(rst_d), .CMOS_CLK(d_cclk), .CMOS_DQ(d_dq),
        .CMOS_VSYNC(d_vsync), .CMOS_HSYNC(d_hsync), .CMOS_VALID(d_valid)
    );

    // Expected output n clocks after release (n=0 is the first edge), 8x6 raster.
    function automatic exp_t small_exp(int n);
        exp_t e;
        int h, line, f;
        h    = n % 8;
        line = (n / 8) % 6;
        f    = n / 48;
        e.valid = (h < 4) && (line < 3);
        e.hsync = (h == 5) || (h == 6);
        e.vsync = (line == 4);
        e.dq    = e.valid ? 16'((line * 4 + h + f) % 65536) : 16'h0000;
        return e;
    endfunction

    // Default 672x520 raster, first frame only.
    function automatic exp_t dflt_exp(int n);
        exp_t e;
        int h, line;
        h    = n % 672;
        line = n / 672;
        e.valid = (h < 640) && (line < 512);
        e.hsync = (h >= 648) && (h < 664);
        e.vsync = (line >= 514) && (line < 518);
        e.dq    = e.valid ? 16'((line * 640 + h) % 65536) : 16'h0000;
        return e;
    endfunction

    task automatic test_reset();
        exp_t obs, e;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        obs = {s_dq, s_valid, s_hsync, s_vsync};
        checks++;
        if (obs !== exp_t'(0)) $display("FAIL reset_outputs got=%h want=%h", obs, exp_t'(0));
        else passed++;
        checks++;
        if (s_cclk !== ~clk) $display("FAIL reset_cmos_clk_high got=%b want=%b", s_cclk, ~clk);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if (s_cclk !== ~clk) $display("FAIL reset_cmos_clk_low got=%b want=%b", s_cclk, ~clk);
        else passed++;
        #3;
        rst = 1'b0;
        cyc = 0;
        q.push_back(small_exp(cyc));
        @(posedge clk); #1;
        e = q.pop_front();
        obs = {s_dq, s_valid, s_hsync, s_vsync};
        $display("n=%0d dq=%0d valid=%b hsync=%b vsync=%b", cyc, s_dq, s_valid, s_hsync, s_vsync);
        checks++;
        if (obs !== e) $display("FAIL first_edge got=%h want=%h", obs, e);
        else passed++;
        checks++;
        if (s_cclk !== ~clk) $display("FAIL run_cmos_clk got=%b want=%b", s_cclk, ~clk);
        else passed++;
        cyc++;
    endtask

    task automatic test_first_line();
        exp_t obs, e;
        for (int k = 0; k < 8; k++) q.push_back(small_exp(cyc + k));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            obs = {s_dq, s_valid, s_hsync, s_vsync};
            $display("n=%0d dq=%0d valid=%b hsync=%b vsync=%b", cyc, s_dq, s_valid, s_hsync, s_vsync);
            checks++;
            if (obs !== e) $display("FAIL first_line n=%0d got=%h want=%h", cyc, obs, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_frame0();
        exp_t obs, e;
        int hs_lines;
        hs_lines = 0;
        for (int n = cyc; n < 48; n++) q.push_back(small_exp(n));
        while (cyc < 48) begin
            @(posedge clk); #1;
            e = q.pop_front();
            obs = {s_dq, s_valid, s_hsync, s_vsync};
            $display("n=%0d dq=%0d valid=%b hsync=%b vsync=%b", cyc, s_dq, s_valid, s_hsync, s_vsync);
            checks++;
            if (obs !== e) $display("FAIL frame0 n=%0d got=%h want=%h", cyc, obs, e);
            else passed++;
            if (cyc >= 24 && (cyc % 8) == 5 && s_hsync) hs_lines++;
            cyc++;
        end
        checks++;
        if (hs_lines !== 3) $display("FAIL blank_hsync_lines got=%0d want=3", hs_lines);
        else passed++;
    endtask

    task automatic test_frame1();
        exp_t obs, e;
        int first_valid, last_dq;
        first_valid = -1;
        last_dq = -1;
        for (int n = cyc; n <= 96; n++) q.push_back(small_exp(n));
        while (cyc <= 96) begin
            @(posedge clk); #1;
            e = q.pop_front();
            obs = {s_dq, s_valid, s_hsync, s_vsync};
            $display("n=%0d dq=%0d valid=%b hsync=%b vsync=%b", cyc, s_dq, s_valid, s_hsync, s_vsync);
            checks++;
            if (obs !== e) $display("FAIL frame1 n=%0d got=%h want=%h", cyc, obs, e);
            else passed++;
            if (s_valid && first_valid < 0) first_valid = cyc;
            if (s_valid && cyc < 96) last_dq = int'(s_dq);
            cyc++;
        end
        checks++;
        if (first_valid !== 48) $display("FAIL frame1_start got=%0d want=48", first_valid);
        else passed++;
        checks++;
        if (last_dq !== 12) $display("FAIL frame1_last_dq got=%0d want=12", last_dq);
        else passed++;
    endtask

    task automatic test_async_reset();
        exp_t obs, e;
        // Run up to frame 2, line 1, pixel 2.
        for (int n = cyc; n <= 106; n++) q.push_back(small_exp(n));
        while (cyc <= 106) begin
            @(posedge clk); #1;
            e = q.pop_front();
            obs = {s_dq, s_valid, s_hsync, s_vsync};
            $display("n=%0d dq=%0d valid=%b hsync=%b vsync=%b", cyc, s_dq, s_valid, s_hsync, s_vsync);
            checks++;
            if (obs !== e) $display("FAIL pre_reset n=%0d got=%h want=%h", cyc, obs, e);
            else passed++;
            cyc++;
        end
        #2;
        rst = 1'b1;
        #1;
        obs = {s_dq, s_valid, s_hsync, s_vsync};
        checks++;
        if (obs !== exp_t'(0)) $display("FAIL async_reset got=%h want=%h", obs, exp_t'(0));
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        for (int n = 0; n < 10; n++) q.push_back(small_exp(n));
        while (cyc < 10) begin
            @(posedge clk); #1;
            e = q.pop_front();
            obs = {s_dq, s_valid, s_hsync, s_vsync};
            $display("n=%0d dq=%0d valid=%b hsync=%b vsync=%b", cyc, s_dq, s_valid, s_hsync, s_vsync);
            checks++;
            if (obs !== e) $display("FAIL restart n=%0d got=%h want=%h", cyc, obs, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_default();
        exp_t obs, e;
        int vcnt, bad;
        @(negedge clk);
        rst_d = 1'b0;
        bad = 0;
        for (int line = 0; line < 2; line++) begin
            vcnt = 0;
            for (int h = 0; h < 672; h++) q.push_back(dflt_exp(line * 672 + h));
            for (int h = 0; h < 672; h++) begin
                @(posedge clk); #1;
                e = q.pop_front();
                obs = {d_dq, d_valid, d_hsync, d_vsync};
                checks++;
                if (obs !== e) begin
                    if (bad < 10) $display("FAIL default n=%0d got=%h want=%h", line * 672 + h, obs, e);
                    bad++;
                end else passed++;
                if (d_valid) vcnt++;
            end
            $display("default line=%0d valid_clocks=%0d", line, vcnt);
            checks++;
            if (vcnt !== 640) $display("FAIL default_valid_count line=%0d got=%0d want=640", line, vcnt);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame0();
        test_frame1();
        test_async_reset();
        test_default();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
